// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial framed link (transmitter and receiver).
// Holds the header layout, payload width, line idle level and the FSM
// state encoding so both ends of the link agree on the frame format.
package serial_frame_pkg;

   localparam int SF_PORT_W = 2;
   localparam int SF_LEN_W  = 4;
   localparam int SF_HDR_W  = SF_PORT_W + SF_LEN_W;
   localparam int SF_DATA_W = (1 << SF_LEN_W) - 1;

   localparam logic LINE_IDLE = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_HDR   = 3'd2,
      ST_DATA  = 3'd3,
      ST_DONE  = 3'd4
   } sf_state_t;

endpackage

// File: rtl/frame_down_counter.sv
// Loadable down-counter used to time the header and payload phases.
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous reset, active low
//   ld     - load ld_val (takes priority over en)
//   en     - decrement by one; holds at zero, never wraps
//   ld_val - value to load
//   co     - carry-out, high while the count is zero
module frame_down_counter
   import serial_frame_pkg::*;
#(
   parameter int W = SF_LEN_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ld,
   input  logic         en,
   input  logic [W-1:0] ld_val,
   output logic         co
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (ld) begin
         cnt_d = ld_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign co = (cnt_q == '0);

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, port field, length field, then
// len payload bits, all MSB first, one bit per clock.
// Ports:
//   clk           - system clock, rising edge
//   rst           - asynchronous reset, active low
//   start         - request strobe, only honoured in IDLE
//   port_num      - destination port, captured with start
//   data_len      - payload bit count, captured with start
//   data_in       - payload, bits [data_len-1:0] are sent
//   ser_out       - serial line, idles high
//   ser_out_valid - high while ser_out carries a payload bit
//   busy          - high from START through DONE
//   done          - one-cycle pulse after the last frame bit
//
// state | meaning
// IDLE  | line high, waiting for start
// START | start bit (line low) for one cycle
// HDR   | shifting out {port, len}, HDR_W cycles
// DATA  | shifting out payload, len cycles
// DONE  | line high, done pulse, back to IDLE
module serial_frame_tx
   import serial_frame_pkg::*;
#(
   parameter int PORT_W = SF_PORT_W,
   parameter int LEN_W  = SF_LEN_W,
   parameter int DATA_W = SF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [PORT_W-1:0] port_num,
   input  logic [LEN_W-1:0]  data_len,
   input  logic [DATA_W-1:0] data_in,
   output logic              ser_out,
   output logic              ser_out_valid,
   output logic              busy,
   output logic              done
);

   localparam int HDR_W = PORT_W + LEN_W;

   sf_state_t state_q, state_d;

   logic [HDR_W-1:0]  hdr_sr_q,  hdr_sr_d;
   logic [LEN_W-1:0]  len_q,     len_d;
   logic [DATA_W-1:0] data_q,    data_d;
   logic [DATA_W-1:0] data_sr_q, data_sr_d;

   logic hdr_ld, hdr_en, hdr_co;
   logic dat_ld, dat_en, dat_co;

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_START;
         ST_START: state_d = ST_HDR;
         ST_HDR: begin
            if (hdr_co) begin
               state_d = (len_q == '0) ? ST_DONE : ST_DATA;
            end
         end
         ST_DATA:  if (dat_co) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // outputs, decoded from state and shift registers only
   always_comb begin
      ser_out       = LINE_IDLE;
      ser_out_valid = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      case (state_q)
         ST_START: begin
            ser_out = ~LINE_IDLE;
            busy    = 1'b1;
         end
         ST_HDR: begin
            ser_out = hdr_sr_q[HDR_W-1];
            busy    = 1'b1;
         end
         ST_DATA: begin
            ser_out       = data_sr_q[DATA_W-1];
            ser_out_valid = 1'b1;
            busy          = 1'b1;
         end
         ST_DONE: begin
            done = 1'b1;
            busy = 1'b1;
         end
         default: ;
      endcase
   end

   // counter control
   always_comb begin
      hdr_ld = (state_q == ST_START);
      hdr_en = (state_q == ST_HDR);
      dat_ld = (state_q == ST_HDR) && hdr_co && (len_q != '0);
      dat_en = (state_q == ST_DATA);
   end

   // capture and shift registers
   always_comb begin
      hdr_sr_d  = hdr_sr_q;
      len_d     = len_q;
      data_d    = data_q;
      data_sr_d = data_sr_q;
      if ((state_q == ST_IDLE) && start) begin
         hdr_sr_d = {port_num, data_len};
         len_d    = data_len;
         data_d   = data_in;
      end
      if (state_q == ST_HDR) begin
         hdr_sr_d = {hdr_sr_q[HDR_W-2:0], LINE_IDLE};
      end
      if (dat_ld) begin
         // left-justify the payload so data[len-1] lands on the MSB
         data_sr_d = data_q << (DATA_W - int'(len_q));
      end else if (state_q == ST_DATA) begin
         data_sr_d = {data_sr_q[DATA_W-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hdr_sr_q  <= '0;
         len_q     <= '0;
         data_q    <= '0;
         data_sr_q <= '0;
      end else begin
         hdr_sr_q  <= hdr_sr_d;
         len_q     <= len_d;
         data_q    <= data_d;
         data_sr_q <= data_sr_d;
      end
   end

   frame_down_counter #(.W(LEN_W)) u_hdr_cnt (
      .clk    (clk),
      .rst    (rst),
      .ld     (hdr_ld),
      .en     (hdr_en),
      .ld_val (LEN_W'(HDR_W - 1)),
      .co     (hdr_co)
   );

   frame_down_counter #(.W(LEN_W)) u_dat_cnt (
      .clk    (clk),
      .rst    (rst),
      .ld     (dat_ld),
      .en     (dat_en),
      .ld_val (len_q - LEN_W'(1)),
      .co     (dat_co)
   );

endmodule
